// File: rtl/ram_bus_controller.sv
`timescale 1ns/1ps
// Valid/ready request stream to pin-level RAM bus master (address, tri-state data, write strobe).
// One transaction in flight; reads return a single-cycle response pulse.
module ram_bus_controller #(
    parameter int unsigned awidth    = 8,
    parameter int unsigned dwidth    = 16,
    parameter int unsigned read_wait = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [awidth-1:0] req_addr,
    input  logic [dwidth-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [dwidth-1:0] rsp_rdata,
    output logic [awidth-1:0] address,
    inout  wire  [dwidth-1:0] data,
    output logic              write_enable
);

    if (read_wait == 0) begin : g_bad_read_wait
        $error("ram_bus_controller: read_wait must be at least 1");
    end

    localparam int unsigned CW = (read_wait < 2) ? 1 : $clog2(read_wait);

    typedef enum logic [2:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        RD_ADDR,
        RD_SAMPLE
    } state_t;

    state_t            state_q;
    logic [awidth-1:0] addr_q;
    logic [dwidth-1:0] wdata_q;
    logic              drive_q;
    logic              we_q;
    logic              rsp_valid_q;
    logic [dwidth-1:0] rdata_q;
    logic [CW-1:0]     cnt_q;

    assign req_ready    = (state_q == IDLE) && !reset;
    assign address      = addr_q;
    assign write_enable = we_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rdata_q;
    assign data         = drive_q ? wdata_q : 'z;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            drive_q     <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            we_q        <= 1'b0;
            case (state_q)
                IDLE: begin
                    // req_ready is just IDLE && !reset, so here acceptance reduces to req_valid
                    if (req_valid) begin
                        addr_q <= req_addr;
                        if (req_write) begin
                            wdata_q <= req_wdata;
                            drive_q <= 1'b1;
                            state_q <= WR_SETUP;
                        end else begin
                            cnt_q   <= CW'(read_wait - 1);
                            state_q <= RD_ADDR;
                        end
                    end
                end
                WR_SETUP: begin
                    we_q    <= 1'b1;
                    state_q <= WR_STROBE;
                end
                WR_STROBE: begin
                    state_q <= WR_HOLD;
                end
                WR_HOLD: begin
                    drive_q <= 1'b0;
                    state_q <= IDLE;
                end
                RD_ADDR: begin
                    if (cnt_q == '0) begin
                        state_q <= RD_SAMPLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                RD_SAMPLE: begin
                    // Sampling one cycle after the address phase gives the RAM a full cycle of settled address
                    rdata_q     <= data;
                    rsp_valid_q <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    drive_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
